// File: rtl/accum_sequencer.sv
// Job sequencer: loads N words into a shared array, starts an external prefix-sum
// engine on it, then streams the in-place results back out in address order.
module accum_sequencer #(
  parameter int N       = 1000,
  parameter int TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [63:0] seed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        controlArr,
  output logic        controlArrWEnable_a,
  output logic [9:0]  controlArrAddr_a,
  output logic [63:0] controlArrWData_a,
  input  logic [63:0] controlArrRData_a,
  output logic        r_enable,
  output logic [63:0] init_i,
  output logic [63:0] init_acc,
  input  logic        w_enable,
  output logic        busy,
  output logic        timeout_err,
  output logic [2:0]  state_dbg
);
  // Handshakes: a word transfers on a rising edge where valid && ready are both 1;
  // valid never depends on ready, and out_valid/out_data hold until the transfer.
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [9:0]     LAST    = 10'(N - 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_RUN, S_RADDR, S_RWAIT, S_OUT
  } state_t;

  state_t         state, state_n;
  logic [9:0]     wcnt, rcnt;
  logic [WDW-1:0] wdog;
  logic [63:0]    seed_q, out_q;
  logic           tmo_q, ready_en;
  logic           accept, last_w, last_r, wd_done;

  // ready_en keeps in_ready low until the first edge after reset is released.
  assign in_ready = ready_en && (state == S_IDLE || state == S_LOAD);
  assign accept   = in_valid && in_ready;
  assign last_w   = (wcnt == LAST);
  assign last_r   = (rcnt == LAST);
  assign wd_done  = (wdog == WD_LAST);

  assign controlArrWEnable_a = accept;
  assign controlArrWData_a   = accept ? in_data : '0;
  assign init_i              = '0;
  assign init_acc            = seed_q;
  assign out_data            = out_q;
  assign timeout_err         = tmo_q;
  assign state_dbg           = state;

  always_comb begin
    state_n          = state;
    r_enable         = 1'b0;
    out_valid        = 1'b0;
    controlArr       = 1'b1;
    busy             = 1'b1;
    controlArrAddr_a = '0;
    case (state)
      S_IDLE: begin
        busy             = 1'b0;
        controlArrAddr_a = wcnt;
        if (accept) state_n = last_w ? S_START : S_LOAD;
      end
      S_LOAD: begin
        controlArrAddr_a = wcnt;
        if (accept && last_w) state_n = S_START;
      end
      S_START: begin
        controlArr = 1'b0;
        r_enable   = 1'b1;
        state_n    = S_RUN;
      end
      S_RUN: begin
        controlArr = 1'b0;
        if (w_enable)     state_n = S_RADDR;
        else if (wd_done) state_n = S_IDLE;
      end
      S_RADDR: begin
        controlArrAddr_a = rcnt;
        state_n          = S_RWAIT;
      end
      S_RWAIT: begin
        controlArrAddr_a = rcnt;
        state_n          = S_OUT;
      end
      S_OUT: begin
        controlArrAddr_a = rcnt;
        out_valid        = 1'b1;
        if (out_ready) state_n = last_r ? S_IDLE : S_RADDR;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wcnt     <= '0;
      rcnt     <= '0;
      wdog     <= '0;
      seed_q   <= '0;
      out_q    <= '0;
      tmo_q    <= 1'b0;
      ready_en <= 1'b0;
    end else begin
      state    <= state_n;
      ready_en <= 1'b1;
      case (state)
        S_IDLE, S_LOAD: begin
          if (accept) begin
            if (state == S_IDLE) begin
              seed_q <= seed;
              tmo_q  <= 1'b0;
            end
            // Counter returns to 0 on the last word so it never reaches N.
            wcnt <= last_w ? '0 : wcnt + 10'd1;
          end
        end
        S_START: begin
          wdog <= '0;
          rcnt <= '0;
        end
        S_RUN: begin
          if (w_enable)     rcnt  <= '0;
          else if (wd_done) tmo_q <= 1'b1;
          else              wdog  <= wdog + WDW'(1);
        end
        S_RWAIT: out_q <= controlArrRData_a;
        S_OUT: begin
          if (out_ready) rcnt <= last_r ? '0 : rcnt + 10'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_accum_sequencer.sv
// Bench for accum_sequencer: three instances (N=4, N=1000, N=2) share a clock and
// each gets a behavioural array plus a prefix-sum engine model.
module tb_accum_sequencer;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [NI];
  logic        in_valid [NI], in_ready [NI], out_valid [NI], out_ready [NI];
  logic [63:0] in_data [NI], seed [NI], out_data [NI];
  logic        ctrl_arr [NI], arr_we [NI];
  logic [9:0]  arr_addr [NI];
  logic [63:0] arr_wdata [NI], arr_rdata [NI];
  logic        r_enable [NI], w_en [NI], spur_we [NI];
  logic        main_we [NI] = '{1'b0, 1'b0, 1'b0};
  logic [63:0] init_i [NI], init_acc [NI];
  logic        busy [NI], timeout_err [NI];
  logic [2:0]  state_dbg [NI];

  int checks = 0;
  int errors = 0;
  logic [63:0] mem [NI][1024];
  int wr_cnt [NI]    = '{0, 0, 0};
  int re_cnt [NI]    = '{0, 0, 0};
  int env_bad [NI]   = '{0, 0, 0};
  int main_left [NI] = '{0, 0, 0};
  int main_lat [NI];
  logic [63:0] main_acc;
  logic [63:0] job_d [1024];
  logic [63:0] exp_q [$];

  function automatic int n_of(input int k);
    return (k == 0) ? 4 : (k == 1) ? 1000 : 2;
  endfunction

  always_comb for (int k = 0; k < NI; k++) w_en[k] = main_we[k] | spur_we[k];

  accum_sequencer #(.N(4), .TIMEOUT(16)) dut0 (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .seed(seed[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .controlArr(ctrl_arr[0]), .controlArrWEnable_a(arr_we[0]),
    .controlArrAddr_a(arr_addr[0]), .controlArrWData_a(arr_wdata[0]),
    .controlArrRData_a(arr_rdata[0]), .r_enable(r_enable[0]), .init_i(init_i[0]),
    .init_acc(init_acc[0]), .w_enable(w_en[0]), .busy(busy[0]),
    .timeout_err(timeout_err[0]), .state_dbg(state_dbg[0]));

  accum_sequencer #(.N(1000), .TIMEOUT(65535)) dut1 (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .seed(seed[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .controlArr(ctrl_arr[1]), .controlArrWEnable_a(arr_we[1]),
    .controlArrAddr_a(arr_addr[1]), .controlArrWData_a(arr_wdata[1]),
    .controlArrRData_a(arr_rdata[1]), .r_enable(r_enable[1]), .init_i(init_i[1]),
    .init_acc(init_acc[1]), .w_enable(w_en[1]), .busy(busy[1]),
    .timeout_err(timeout_err[1]), .state_dbg(state_dbg[1]));

  accum_sequencer #(.N(2), .TIMEOUT(16)) dut2 (
    .clk(clk), .rst(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .seed(seed[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_data(out_data[2]), .controlArr(ctrl_arr[2]), .controlArrWEnable_a(arr_we[2]),
    .controlArrAddr_a(arr_addr[2]), .controlArrWData_a(arr_wdata[2]),
    .controlArrRData_a(arr_rdata[2]), .r_enable(r_enable[2]), .init_i(init_i[2]),
    .init_acc(init_acc[2]), .w_enable(w_en[2]), .busy(busy[2]),
    .timeout_err(timeout_err[2]), .state_dbg(state_dbg[2]));

  // Array with one-cycle read latency, plus the engine: after a start pulse and a
  // programmable delay it turns the array into running sums from init_acc.
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      main_we[k] <= 1'b0;
      if (busy[k] === 1'b1 && int'(arr_addr[k]) >= n_of(k)) env_bad[k]++;
      if (ctrl_arr[k] === 1'b1 && arr_we[k] === 1'b1) begin
        mem[k][arr_addr[k]] = arr_wdata[k];
        wr_cnt[k]++;
      end
      arr_rdata[k] <= mem[k][arr_addr[k]];
      if (r_enable[k] === 1'b1) re_cnt[k]++;
      if (rst[k] === 1'b1) main_left[k] = 0;
      else if (r_enable[k] === 1'b1) main_left[k] = main_lat[k];
      else if (main_left[k] > 0) begin
        main_left[k]--;
        if (main_left[k] == 0) begin
          if (ctrl_arr[k] !== 1'b0 || init_i[k] !== 64'd0) env_bad[k]++;
          main_acc = init_acc[k];
          for (int i = 0; i < n_of(k); i++) begin
            main_acc  = main_acc + mem[k][i];
            mem[k][i] = main_acc;
          end
          main_we[k] <= 1'b1;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit reached=1 required=0");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input int k, input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL i%0d_%s got=%0b exp=%0b", k, tag, got, exp);
    end
  endtask

  task automatic chk64(input int k, input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL i%0d_%s got=%0h exp=%0h", k, tag, got, exp);
    end
  endtask

  task automatic do_reset(input int k);
    rst[k] = 1'b1; in_valid[k] = 1'b0; out_ready[k] = 1'b0; spur_we[k] = 1'b0;
    tick();
    tick();
    chk1(k, "rst_ctrl_arr", ctrl_arr[k], 1'b1);
    chk1(k, "rst_we", arr_we[k], 1'b0);
    chk64(k, "rst_addr", 64'(arr_addr[k]), 64'd0);
    chk64(k, "rst_wdata", arr_wdata[k], 64'd0);
    chk1(k, "rst_r_enable", r_enable[k], 1'b0);
    chk1(k, "rst_in_ready", in_ready[k], 1'b0);
    chk1(k, "rst_out_valid", out_valid[k], 1'b0);
    chk64(k, "rst_out_data", out_data[k], 64'd0);
    chk1(k, "rst_busy", busy[k], 1'b0);
    chk1(k, "rst_timeout_err", timeout_err[k], 1'b0);
    chk64(k, "rst_init_acc", init_acc[k], 64'd0);
    chk64(k, "rst_init_i", init_i[k], 64'd0);
    rst[k] = 1'b0;
    #1;
    chk1(k, "in_ready_before_edge", in_ready[k], 1'b0);
    tick();
    chk1(k, "in_ready_after_rst", in_ready[k], 1'b1);
  endtask

  // Loads job_d[0..n-1]; returns one cycle into START. Reference sums go to exp_q.
  task automatic send_job(input int k, input int n, input logic [63:0] sd,
                          input bit gaps, input bit spur);
    logic [63:0] acc;
    int wr0, bad;
    acc = sd;
    wr0 = wr_cnt[k];
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid[k] = 1'b0;
          if (spur && i > 0) spur_we[k] = ($urandom_range(0, 1) == 1);
          #1;
          chk1(k, "idle_we", arr_we[k], 1'b0);
          chk64(k, "idle_wdata", arr_wdata[k], 64'd0);
          tick();
          spur_we[k] = 1'b0;
          if (i > 0) begin
            chk1(k, "load_busy", busy[k], 1'b1);
            chk1(k, "load_in_ready", in_ready[k], 1'b1);
            chk1(k, "load_r_enable", r_enable[k], 1'b0);
          end
        end
      end
      in_valid[k] = 1'b1;
      in_data[k]  = job_d[i];
      seed[k]     = (i == 0) ? sd : {$urandom, $urandom};
      #1;
      chk1(k, "acc_in_ready", in_ready[k], 1'b1);
      chk1(k, "acc_we", arr_we[k], 1'b1);
      chk64(k, "acc_addr", 64'(arr_addr[k]), 64'(i));
      chk64(k, "acc_wdata", arr_wdata[k], job_d[i]);
      tick();
      in_valid[k] = 1'b0;
      acc = acc + job_d[i];
      exp_q.push_back(acc);
      if (i == 0) chk1(k, "tmo_clear_on_accept", timeout_err[k], 1'b0);
    end
    chk1(k, "start_r_enable", r_enable[k], 1'b1);
    chk1(k, "start_ctrl_arr", ctrl_arr[k], 1'b0);
    chk1(k, "start_in_ready", in_ready[k], 1'b0);
    chk1(k, "start_busy", busy[k], 1'b1);
    chk64(k, "start_init_acc", init_acc[k], sd);
    chk64(k, "start_init_i", init_i[k], 64'd0);
    chk64(k, "write_count", 64'(wr_cnt[k] - wr0), 64'(n));
    bad = 0;
    for (int i = 0; i < n; i++) if (mem[k][i] !== job_d[i]) bad++;
    chk64(k, "array_contents", 64'(bad), 64'd0);
  endtask

  task automatic collect(input int k, input int n, input bit rand_rdy,
                         input bit hold_iv, input bit tput);
    int got, idle, cyc, last_hs;
    got = 0; idle = 0; cyc = 0; last_hs = -1;
    while (got < n) begin
      out_ready[k] = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (hold_iv) begin
        in_valid[k] = 1'b1;
        in_data[k]  = {$urandom, $urandom};
      end
      #1;
      if (hold_iv) begin
        chk1(k, "busy_in_ready", in_ready[k], 1'b0);
        chk1(k, "busy_we", arr_we[k], 1'b0);
      end
      if (out_valid[k] === 1'b1) begin
        chk64(k, "out_data", out_data[k], exp_q[0]);
        if (out_ready[k]) begin
          chk64(k, "out_addr_order", 64'(arr_addr[k]), 64'(got));
          if (tput && last_hs >= 0) chk64(k, "throughput_gap", 64'(cyc - last_hs), 64'd3);
          last_hs = cyc;
          void'(exp_q.pop_front());
          got++;
          idle = 0;
        end
      end else begin
        idle++;
        if (idle > 300) begin
          checks++;
          errors++;
          $error("FAIL i%0d_wait_out_valid waited=%0d limit=300", k, idle);
          break;
        end
      end
      tick();
      cyc++;
    end
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b0;
    #1;
    chk1(k, "done_busy", busy[k], 1'b0);
    chk1(k, "done_out_valid", out_valid[k], 1'b0);
    chk1(k, "done_in_ready", in_ready[k], 1'b1);
  endtask

  initial begin
    int re0;
    logic [63:0] sd;
    logic [31:0] r32;
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1; in_valid[k] = 1'b0; in_data[k] = '0; seed[k] = '0;
      out_ready[k] = 1'b0; spur_we[k] = 1'b0; main_lat[k] = 0;
    end
    for (int k = 0; k < NI; k++) do_reset(k);

    // N=4, seed 0, inputs 1..4, drained back to back.
    main_lat[0] = 3;
    for (int i = 0; i < 4; i++) job_d[i] = 64'(i + 1);
    re0 = re_cnt[0];
    send_job(0, 4, 64'd0, 1'b0, 1'b0);
    collect(0, 4, 1'b0, 1'b0, 1'b1);
    chk64(0, "r_enable_pulses", 64'(re_cnt[0] - re0), 64'd1);

    // Engine never answers: watchdog expires after 16 RUN cycles.
    main_lat[0] = 0;
    for (int i = 0; i < 4; i++) job_d[i] = {$urandom, $urandom};
    re0 = re_cnt[0];
    send_job(0, 4, {$urandom, $urandom}, 1'b1, 1'b1);
    for (int j = 1; j <= 16; j++) begin
      tick();
      chk1(0, "run_busy", busy[0], 1'b1);
      chk1(0, "run_no_tmo", timeout_err[0], 1'b0);
      chk1(0, "run_no_out", out_valid[0], 1'b0);
    end
    tick();
    chk1(0, "tmo_set", timeout_err[0], 1'b1);
    chk1(0, "tmo_idle", busy[0], 1'b0);
    chk1(0, "tmo_in_ready", in_ready[0], 1'b1);
    exp_q.delete();
    repeat (5) begin
      tick();
      chk1(0, "tmo_no_out", out_valid[0], 1'b0);
      chk1(0, "tmo_sticky", timeout_err[0], 1'b1);
    end
    chk64(0, "tmo_r_enable_pulses", 64'(re_cnt[0] - re0), 64'd1);

    // Reset during RUN, then a fresh job.
    main_lat[0] = 6;
    for (int i = 0; i < 4; i++) job_d[i] = {$urandom, $urandom};
    send_job(0, 4, {$urandom, $urandom}, 1'b1, 1'b1);
    tick();
    tick();
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    exp_q.delete();
    chk1(0, "midrst_busy", busy[0], 1'b0);
    chk1(0, "midrst_out_valid", out_valid[0], 1'b0);
    chk64(0, "midrst_out_data", out_data[0], 64'd0);
    chk64(0, "midrst_init_acc", init_acc[0], 64'd0);
    re0 = re_cnt[0];
    repeat (10) begin
      tick();
      chk1(0, "midrst_no_out", out_valid[0], 1'b0);
      chk1(0, "midrst_no_start", r_enable[0], 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      r32 = $urandom;
      job_d[i] = {{32{r32[31]}}, r32};
    end
    send_job(0, 4, {$urandom, $urandom}, 1'b1, 1'b1);
    collect(0, 4, 1'b1, 1'b1, 1'b0);
    chk64(0, "fresh_r_enable_pulses", 64'(re_cnt[0] - re0), 64'd1);

    // N=2, seed -5, inputs 7 and -2.
    main_lat[2] = 4;
    job_d[0] = 64'd7;
    job_d[1] = -64'sd2;
    send_job(2, 2, -64'sd5, 1'b0, 1'b0);
    tick();
    chk64(2, "run_init_acc", init_acc[2], -64'sd5);
    chk1(2, "run_r_enable", r_enable[2], 1'b0);
    chk1(2, "run_ctrl_arr", ctrl_arr[2], 1'b0);
    collect(2, 2, 1'b0, 1'b0, 1'b1);

    for (int r = 0; r < 3; r++) begin
      main_lat[2] = $urandom_range(1, 10);
      for (int i = 0; i < 2; i++) job_d[i] = {$urandom, $urandom};
      send_job(2, 2, {$urandom, $urandom}, 1'b1, 1'b1);
      collect(2, 2, 1'b1, 1'b1, 1'b0);
    end

    // N=1000 random signed 32-bit words, random back-pressure.
    main_lat[1] = 7;
    for (int i = 0; i < 1000; i++) begin
      r32 = $urandom;
      job_d[i] = {{32{r32[31]}}, r32};
    end
    r32 = $urandom;
    sd = {{32{r32[31]}}, r32};
    re0 = re_cnt[1];
    send_job(1, 1000, sd, 1'b1, 1'b0);
    collect(1, 1000, 1'b1, 1'b0, 1'b0);
    chk64(1, "r_enable_pulses", 64'(re_cnt[1] - re0), 64'd1);

    for (int k = 0; k < NI; k++) chk64(k, "env_violations", 64'(env_bad[k]), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/accum_sequencer.md
ACCUM_SEQUENCER -- requirements
Module: accum_sequencer

Interface
Parameters:
REQ-001 SHALL have parameter N, default 1000: words per job (1..1024).
REQ-002 SHALL have parameter TIMEOUT, default 65535: max cycles waited for main completion.

Ports:
REQ-003 SHALL have clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have in_valid / in_ready  in/out  1/1  input word handshake.
REQ-006 SHALL have in_data  in  64  signed input word.
REQ-007 SHALL have seed  in  64  accumulator seed, sampled on the first accepted word of a job.
REQ-008 SHALL have out_valid / out_ready  out/in  1/1  result word handshake.
REQ-009 SHALL have out_data  out  64  signed result word (prefix sum).
REQ-010 SHALL have controlArr  out  1  1 = sequencer owns the array port, 0 = main owns it.
REQ-011 SHALL have controlArrWEnable_a  out  1  array write enable.
REQ-012 SHALL have controlArrAddr_a  out  10  array address.
REQ-013 SHALL have controlArrWData_a  out  64  array write data.
REQ-014 SHALL have controlArrRData_a  in  64  array read data, valid the cycle after its address is driven.
REQ-015 SHALL have r_enable  out  1  one-cycle start pulse to main.
REQ-016 SHALL have init_i / init_acc  out  64/64  main start values: 0 / latched seed.
REQ-017 SHALL have w_enable  in  1  main completion pulse.
REQ-018 SHALL have busy / timeout_err  out  1/1  job in progress / sticky watchdog flag.

Function
REQ-019 SHALL implement states IDLE, LOAD, START, RUN, RADDR, RWAIT, OUT.
REQ-020 IDLE/LOAD: in_ready=1; each accepted word (in_valid&in_ready) SHALL write in_data to address wcnt (WEnable=1 that cycle), wcnt+1; IDLE->LOAD on first accept.
REQ-021 In every cycle with no accepted word, controlArrWEnable_a SHALL be 0.
REQ-022 The N-th accepted word SHALL move to START; in_ready SHALL be 0 in all states other than IDLE/LOAD.
REQ-023 START: controlArr=0, r_enable=1 for exactly one cycle, watchdog cleared; next state RUN.
REQ-024 RUN: controlArr=0, r_enable=0; w_enable=1 SHALL move to RADDR with rcnt=0.
REQ-025 RUN: watchdog reaching TIMEOUT without w_enable SHALL set timeout_err and move to IDLE, discarding the job.
REQ-026 w_enable outside RUN SHALL be ignored.
REQ-027 RADDR: controlArr=1, WEnable=0, addr=rcnt; next state RWAIT.
REQ-028 RWAIT: capture controlArrRData_a into out_data, out_valid=1; next state OUT.
REQ-029 OUT: out_valid, out_data held stable until out_ready=1.
REQ-030 On the out_ready handshake: if rcnt==N-1, go to IDLE; else rcnt+1 and go to RADDR.
REQ-031 Result order SHALL be address 0..N-1; throughput SHALL be one word per 3 cycles when out_ready is held 1.
REQ-032 controlArr SHALL be 1 in all states except START and RUN.
REQ-033 busy SHALL be 1 in all states except IDLE.
REQ-034 Addresses SHALL never exceed N-1; counters SHALL not wrap within a job.
REQ-035 timeout_err SHALL clear on rst or on the first accepted word of a new job.
REQ-036 init_i SHALL be constant 0; init_acc SHALL hold the latched seed from START through RUN.

Reset
REQ-037 rst=1 at any clock edge SHALL force state IDLE, wcnt=rcnt=0, watchdog=0.
REQ-038 rst SHALL also force outputs: controlArr=1, WEnable=0, addr=0, WData=0, r_enable=0, in_ready=0, out_valid=0, out_data=0, busy=0, timeout_err=0, init_acc=0.
REQ-039 in_ready SHALL rise the cycle after rst deasserts.
REQ-040 rst mid-job (any state) SHALL abandon the job with no further r_enable or out_valid.

Verification
REQ-041 N=4, seed=0, inputs 1,2,3,4, model main returning prefix sums -> writes addr 0..3, one r_enable, outputs 1,3,6,10.
REQ-042 N=1000 random signed 32-bit inputs, random out_ready -> 1000 outputs equal running sum; out_data stable while stalled.
REQ-043 seed=-5, N=2, inputs 7,-2 -> init_acc=-5 during RUN; outputs 2,0.
REQ-044 TIMEOUT=16, main never pulses w_enable -> timeout_err=1 at cycle 16 of RUN, state IDLE, no out_valid.
REQ-045 rst asserted in RUN, then a fresh N=4 job -> no stale outputs; the new job is correct.
REQ-046 in_valid held high during RUN/OUT, spurious w_enable in LOAD -> no extra writes, no state change.
